// File: rtl/maf_norm_stage_pkg.sv
// Shared definitions for the MAF normalization stage: mode encodings, widths
// and the registered result bundle.
package maf_norm_stage_pkg;

    localparam int W      = 74;
    localparam int LW     = 37;
    localparam int SHW    = 10;
    localparam int SAW    = 7;
    localparam int PERIOD = 10;

    localparam logic [2:0] CONT_DBL  = 3'd0;
    localparam logic [2:0] CONT_DUAL = 3'd1;
    localparam logic [2:0] CONT_WIDE = 3'd2;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } skid_st_e;

    typedef struct packed {
        logic [W-1:0] mant;
        logic [1:0]   zero;
        logic [11:0]  e;
        logic         s2;
        logic         s2h;
        logic [3:0]   trap0;
        logic [3:0]   trap1;
        logic [2:0]   cont;
        logic [11:0]  d;
    } norm_res_t;

endpackage

// File: rtl/maf_norm_stage_shift.sv
// Combinational lane shifter: left-shifts a full-width or lane-width magnitude,
// zero-filling from the LSB, and flags a zero input.
module maf_norm_shift
    import maf_norm_stage_pkg::*;
(
    input  logic [W-1:0]   data,
    input  logic [SAW-1:0] sa,
    input  logic           wide,
    output logic [W-1:0]   shifted,
    output logic           zero
);

    logic [W-1:0]   lane_mask;
    logic [W-1:0]   din;
    logic [SAW-1:0] lane_w;

    always_comb begin
        lane_mask = wide ? {W{1'b1}} : {{(W-LW){1'b0}}, {LW{1'b1}}};
        lane_w    = wide ? SAW'(W) : SAW'(LW);
        din       = data & lane_mask;
        zero      = (din == '0);
        // Masking after the shift keeps lane bits from leaking above the lane top.
        if (sa >= lane_w) begin
            shifted = '0;
        end else begin
            shifted = (din << sa) & lane_mask;
        end
    end

endmodule

// File: rtl/maf_norm_stage.sv
// MAF normalization stage: per-lane LZA-driven left shift, registered behind a
// valid/ready handshake with a one-entry skid buffer.
module maf_norm_stage
    import maf_norm_stage_pkg::*;
(
    input  logic           clk,
    input  logic           rstn,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2:0]     cont_T4_3,
    input  logic [W-1:0]   p_reg,
    input  logic [SHW-1:0] sh_num,
    input  logic [1:0]     esh,
    input  logic [1:0]     revising_T4_3,
    input  logic [11:0]    E_T4_3,
    input  logic           s2_T4_3,
    input  logic           s2h_T4_3,
    input  logic [3:0]     trap_T4_3_0,
    input  logic [3:0]     trap_T4_3_1,
    input  logic [11:0]    d_T4_3,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   mant_T5,
    output logic [1:0]     zero_T5,
    output logic [11:0]    E_T5,
    output logic           s2_T5,
    output logic           s2h_T5,
    output logic [3:0]     trap_T5_0,
    output logic [3:0]     trap_T5_1,
    output logic [2:0]     cont_T5,
    output logic [11:0]    d_T5
);

    logic [SAW-1:0] sa_full;
    logic [SAW-1:0] sa_hi;
    logic [SAW-1:0] sa_lo;
    logic [W-1:0]   a_data;
    logic [SAW-1:0] a_sa;
    logic           a_wide;
    logic [W-1:0]   a_shifted;
    logic           a_zero;
    logic [W-1:0]   b_shifted;
    logic           b_zero;
    norm_res_t      res_in;

    skid_st_e  state_q, state_d;
    logic      out_valid_q, out_valid_d;
    norm_res_t out_q, out_d;
    norm_res_t skid_q, skid_d;

    logic in_xfer;
    logic is_dual;

    always_comb begin
        is_dual = (cont_T4_3 == CONT_DUAL);
        // cont=2 always trusts the LZA count; cont=0 only when esh[0] says so.
        sa_full = ((cont_T4_3 == CONT_WIDE) || esh[0]) ? {1'b0, sh_num[5:0]} : '0;
        sa_full = sa_full + {{(SAW-1){1'b0}}, revising_T4_3[0]};
        sa_hi   = esh[1] ? {2'b0, sh_num[9:5]} : '0;
        sa_hi   = sa_hi + {{(SAW-1){1'b0}}, revising_T4_3[1]};
        sa_lo   = esh[0] ? {2'b0, sh_num[4:0]} : '0;
        sa_lo   = sa_lo + {{(SAW-1){1'b0}}, revising_T4_3[0]};
        a_data  = is_dual ? {{(W-LW){1'b0}}, p_reg[W-1:LW]} : p_reg;
        a_sa    = is_dual ? sa_hi : sa_full;
        a_wide  = !is_dual;
    end

    maf_norm_shift u_shift_hi (
        .data    (a_data),
        .sa      (a_sa),
        .wide    (a_wide),
        .shifted (a_shifted),
        .zero    (a_zero)
    );

    maf_norm_shift u_shift_lo (
        .data    ({{(W-LW){1'b0}}, p_reg[LW-1:0]}),
        .sa      (sa_lo),
        .wide    (1'b0),
        .shifted (b_shifted),
        .zero    (b_zero)
    );

    always_comb begin
        res_in       = '0;
        res_in.e     = E_T4_3;
        res_in.s2    = s2_T4_3;
        res_in.s2h   = s2h_T4_3;
        res_in.trap0 = trap_T4_3_0;
        res_in.trap1 = trap_T4_3_1;
        res_in.cont  = cont_T4_3;
        res_in.d     = d_T4_3;
        case (cont_T4_3)
            CONT_DBL, CONT_WIDE: begin
                res_in.mant = a_shifted;
                res_in.zero = {1'b0, a_zero};
            end
            CONT_DUAL: begin
                res_in.mant = {a_shifted[LW-1:0], b_shifted[LW-1:0]};
                res_in.zero = {a_zero, b_zero};
            end
            default: begin
                res_in.mant = '0;
                res_in.zero = 2'b00;
            end
        endcase
    end

    assign in_ready = (state_q == ST_EMPTY);
    assign in_xfer  = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        skid_d      = skid_q;
        if (flush) begin
            state_d     = ST_EMPTY;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        if (!out_valid_q || out_ready) begin
                            out_d       = res_in;
                            out_valid_d = 1'b1;
                        end else begin
                            skid_d  = res_in;
                            state_d = ST_FULL;
                        end
                    end else if (out_ready) begin
                        out_valid_d = 1'b0;
                    end
                end
                ST_FULL: begin
                    // Output is necessarily valid here; drain the skid entry first.
                    if (out_ready) begin
                        out_d   = skid_q;
                        state_d = ST_EMPTY;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            skid_q      <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            skid_q      <= skid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign mant_T5   = out_q.mant;
    assign zero_T5   = out_q.zero;
    assign E_T5      = out_q.e;
    assign s2_T5     = out_q.s2;
    assign s2h_T5    = out_q.s2h;
    assign trap_T5_0 = out_q.trap0;
    assign trap_T5_1 = out_q.trap1;
    assign cont_T5   = out_q.cont;
    assign d_T5      = out_q.d;

endmodule

// File: tb/tb_maf_norm_stage.sv
// Directed bench for maf_norm_stage: shift modes, lane isolation, stall/skid,
// flush and asynchronous reset.
module tb_maf_norm_stage;

    logic        clk;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  cont_T4_3;
    logic [73:0] p_reg;
    logic [9:0]  sh_num;
    logic [1:0]  esh;
    logic [1:0]  revising_T4_3;
    logic [11:0] E_T4_3;
    logic        s2_T4_3;
    logic        s2h_T4_3;
    logic [3:0]  trap_T4_3_0;
    logic [3:0]  trap_T4_3_1;
    logic [11:0] d_T4_3;
    logic        out_valid;
    logic        out_ready;
    logic [73:0] mant_T5;
    logic [1:0]  zero_T5;
    logic [11:0] E_T5;
    logic        s2_T5;
    logic        s2h_T5;
    logic [3:0]  trap_T5_0;
    logic [3:0]  trap_T5_1;
    logic [2:0]  cont_T5;
    logic [11:0] d_T5;

    int n_tests = 0;
    int n_fail  = 0;

    maf_norm_stage dut (
        .clk           (clk),
        .rstn          (rstn),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .cont_T4_3     (cont_T4_3),
        .p_reg         (p_reg),
        .sh_num        (sh_num),
        .esh           (esh),
        .revising_T4_3 (revising_T4_3),
        .E_T4_3        (E_T4_3),
        .s2_T4_3       (s2_T4_3),
        .s2h_T4_3      (s2h_T4_3),
        .trap_T4_3_0   (trap_T4_3_0),
        .trap_T4_3_1   (trap_T4_3_1),
        .d_T4_3        (d_T4_3),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .mant_T5       (mant_T5),
        .zero_T5       (zero_T5),
        .E_T5          (E_T5),
        .s2_T5         (s2_T5),
        .s2h_T5        (s2h_T5),
        .trap_T5_0     (trap_T5_0),
        .trap_T5_1     (trap_T5_1),
        .cont_T5       (cont_T5),
        .d_T5          (d_T5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_vec(input string tag, input logic [2:0] cont, input logic [73:0] p,
                           input logic [9:0] sh, input logic [1:0] e, input logic [1:0] rev,
                           input logic [73:0] exp_m, input logic [1:0] exp_z);
        @(negedge clk);
        cont_T4_3     = cont;
        p_reg         = p;
        sh_num        = sh;
        esh           = e;
        revising_T4_3 = rev;
        in_valid      = 1'b1;
        out_ready     = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_mant"}, mant_T5, exp_m);
        chk({tag, "_zero"}, zero_T5, exp_z);
    endtask

    task automatic drive_e(input logic [11:0] e_val);
        E_T4_3   = e_val;
        in_valid = 1'b1;
    endtask

    initial begin
        rstn          = 1'b0;
        flush         = 1'b0;
        in_valid      = 1'b0;
        out_ready     = 1'b1;
        cont_T4_3     = 3'd0;
        p_reg         = '0;
        sh_num        = '0;
        esh           = 2'b00;
        revising_T4_3 = 2'b00;
        E_T4_3        = 12'hABC;
        s2_T4_3       = 1'b1;
        s2h_T4_3      = 1'b0;
        trap_T4_3_0   = 4'h5;
        trap_T4_3_1   = 4'hA;
        d_T4_3        = 12'h3C3;

        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_mant", mant_T5, 0);
        chk("rst_e", E_T5, 0);
        @(negedge clk);
        rstn = 1'b1;

        // cont=0: bit 50 shifted by 23 lands on bit 73
        run_vec("dbl_23", 3'd0, {23'b0, 1'b1, 50'b0}, 10'd23, 2'b01, 2'b00,
                {1'b1, 73'b0}, 2'b00);
        chk("pass_e", E_T5, 12'hABC);
        chk("pass_s2", {s2h_T5, s2_T5}, 2'b01);
        chk("pass_trap", {trap_T5_1, trap_T5_0}, 8'hA5);
        chk("pass_d", d_T5, 12'h3C3);
        chk("pass_cont", cont_T5, 0);
        // cont=0 with esh[0]=0: only the revising bit shifts
        run_vec("dbl_noesh", 3'd0, 74'h1, 10'd23, 2'b00, 2'b01, 74'h2, 2'b00);
        // MSB shifted out of a full-width word
        run_vec("dbl_out", 3'd0, {1'b1, 73'b0}, 10'd1, 2'b01, 2'b00, 74'h0, 2'b00);
        // dual: hi sa=32 -> hi bit 32; lo bit 8 + 29 = 37 drops out, never crosses
        run_vec("dual_a", 3'd1, {37'h1, 37'h100}, {5'd31, 5'd28}, 2'b11, 2'b11,
                {37'h1_0000_0000, 37'h0}, 2'b00);
        // dual: both lanes land exactly on lane bit 36
        run_vec("dual_b", 3'd1, {37'h10, 37'h100}, {5'd31, 5'd27}, 2'b11, 2'b11,
                {37'h10_0000_0000, 37'h10_0000_0000}, 2'b00);
        // dual: hi lane zero, lo count invalid so lo shifts by revising only
        run_vec("dual_c", 3'd1, {37'h0, 37'h3}, {5'd4, 5'd5}, 2'b10, 2'b01,
                {37'h0, 37'h6}, 2'b10);
        // cont=2 ignores esh
        run_vec("wide_noesh", 3'd2, 74'h1, 10'd10, 2'b00, 2'b00, 74'h400, 2'b00);
        run_vec("wide_zero", 3'd2, 74'h0, 10'd63, 2'b00, 2'b01, 74'h0, 2'b01);
        run_vec("cont5", 3'd5, 74'h0, 10'd63, 2'b00, 2'b01, 74'h0, 2'b00);
        run_vec("cont7", 3'd7, 74'h1, 10'd3, 2'b11, 2'b00, 74'h0, 2'b00);

        // drain, then stall with back-to-back inputs A, B, C
        @(negedge clk);
        chk("idle_valid", out_valid, 0);
        cont_T4_3 = 3'd0;
        out_ready = 1'b0;
        drive_e(12'h111);
        @(negedge clk);
        chk("st_a_valid", out_valid, 1);
        chk("st_a_e", E_T5, 12'h111);
        chk("st_a_ready", in_ready, 1);
        drive_e(12'h222);
        @(negedge clk);
        chk("st_b_ready", in_ready, 0);
        chk("st_b_e", E_T5, 12'h111);
        drive_e(12'h333);
        @(negedge clk);
        chk("st_c_e", E_T5, 12'h111);
        chk("st_c_valid", out_valid, 1);
        chk("st_c_ready", in_ready, 0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("rel_b_e", E_T5, 12'h222);
        chk("rel_b_valid", out_valid, 1);
        chk("rel_b_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("rel_c_e", E_T5, 12'h333);
        chk("rel_c_valid", out_valid, 1);
        @(negedge clk);
        chk("rel_end_valid", out_valid, 0);

        // flush with output and skid both full
        out_ready = 1'b0;
        drive_e(12'h444);
        @(negedge clk);
        drive_e(12'h555);
        @(negedge clk);
        in_valid = 1'b0;
        chk("fl_full_ready", in_ready, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fl_valid", out_valid, 0);
        chk("fl_ready", in_ready, 1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("fl_noskid", out_valid, 0);

        // flush drops a same-cycle input transfer
        flush = 1'b1;
        drive_e(12'h666);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_drop_valid", out_valid, 0);

        // async reset while stalled with skid full
        out_ready = 1'b0;
        drive_e(12'h777);
        @(negedge clk);
        drive_e(12'h888);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_ready", in_ready, 1);
        chk("ar_e", E_T5, 0);
        chk("ar_mant", mant_T5, 0);
        @(negedge clk);
        rstn      = 1'b1;
        out_ready = 1'b1;
        cont_T4_3 = 3'd0;
        p_reg     = 74'h1;
        sh_num    = 10'd4;
        esh       = 2'b01;
        revising_T4_3 = 2'b00;
        drive_e(12'h999);
        @(negedge clk);
        in_valid = 1'b0;
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_e", E_T5, 12'h999);
        chk("post_rst_mant", mant_T5, 74'h10);
        @(negedge clk);
        chk("post_rst_drain", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
